// File: rtl/inst_mem_pipe.sv
// Pipelined, byte-addressed instruction memory with a program-load write port,
// valid/ready fetch handshake, 1- or 2-cycle read latency, stall/flush control
// and error flagging for misaligned or out-of-range fetches.
module inst_mem_pipe #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_inst,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] req_word;
  logic [ADDR_WIDTH-1:0] wr_word;
  logic [IW-1:0]         req_idx;
  logic [IW-1:0]         wr_idx;
  logic                  req_err;
  logic                  wr_ok;
  logic                  accept;

  // Fetch-stage result, before any pipeline register
  logic                  f_valid;
  logic [DATA_WIDTH-1:0] f_inst;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_err;

  // Values feeding the output register (fetch result or the extra stage)
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_inst;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_err;

  assign req_word = req_addr >> OFF;
  assign wr_word  = wr_addr >> OFF;
  assign req_idx  = req_word[IW-1:0];
  assign wr_idx   = wr_word[IW-1:0];

  // Full-width index compare so out-of-range addresses never alias into the array
  assign req_err  = ((req_addr & OFF_MASK) != '0) || (req_word >= DEPTH_A);
  assign wr_ok    = wr_en && ((wr_addr & OFF_MASK) == '0) && (wr_word < DEPTH_A);

  assign req_ready = !stall && !flush && !rst;
  assign accept    = req_valid && req_ready;

  // Program-load write port; array is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Array read with write-first bypass and error substitution
  always_comb begin
    f_valid = accept;
    f_addr  = req_addr;
    f_err   = req_err;
    f_inst  = mem[req_idx];
    if (req_err) begin
      f_inst = NOP_WORD;
    end else if (wr_ok && (wr_idx == req_idx)) begin
      f_inst = wr_data;
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_inst;
      logic [ADDR_WIDTH-1:0] s1_addr;
      logic                  s1_err;

      // Intermediate stage between array read and output register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_inst  <= NOP_WORD;
          s1_addr  <= '0;
          s1_err   <= 1'b0;
        end else if (flush) begin
          s1_valid <= 1'b0;
        end else if (!stall) begin
          s1_valid <= f_valid;
          if (f_valid) begin
            s1_inst <= f_inst;
            s1_addr <= f_addr;
            s1_err  <= f_err;
          end
        end
      end

      assign o_valid = s1_valid;
      assign o_inst  = s1_inst;
      assign o_addr  = s1_addr;
      assign o_err   = s1_err;
    end else begin : g_lat1
      assign o_valid = f_valid;
      assign o_inst  = f_inst;
      assign o_addr  = f_addr;
      assign o_err   = f_err;
    end
  endgenerate

  // Output register: flush beats stall; bubbles keep the last inst/addr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= NOP_WORD;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= NOP_WORD;
      rsp_err   <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= o_valid;
      if (o_valid) begin
        rsp_inst <= o_inst;
        rsp_addr <= o_addr;
        rsp_err  <= o_err;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Self-checking bench: drives one LATENCY=1 and one LATENCY=2 instance with the
// same directed stimulus and compares both against a transaction-level model.
module tb_inst_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        stall;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        rr   [2];
  logic        dv   [2];
  logic [31:0] dinst[2];
  logic [31:0] daddr[2];
  logic        derr [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_mem_pipe #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(32), .LATENCY(1), .NOP_WORD(32'h0)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr[0]),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(dv[0]), .rsp_inst(dinst[0]), .rsp_addr(daddr[0]), .rsp_err(derr[0]));

  inst_mem_pipe #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(32), .LATENCY(2), .NOP_WORD(32'h0)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr[1]),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(dv[1]), .rsp_inst(dinst[1]), .rsp_addr(daddr[1]), .rsp_err(derr[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each accepted fetch becomes a ticket that must survive LATENCY unstalled
  // edges before it appears at the output; flush and reset drop all tickets.
  typedef struct {
    int          k;
    int          cnt;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t        q[$];
  ent_t        nq[$];
  ent_t        e;
  logic [31:0] sh [64];
  logic        m_valid[2];
  logic [31:0] m_inst [2];
  logic [31:0] m_addr [2];
  logic        m_err  [2];
  logic        acc;
  logic        ferr;
  logic [31:0] finst;
  logic        wok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0;
        m_inst[k]  = 32'h0;
        m_addr[k]  = 32'h0;
        m_err[k]   = 1'b0;
      end
    end else begin
      acc   = req_valid && !stall && !flush;
      ferr  = (req_addr % 4 != 0) || (req_addr / 4 >= 64);
      wok   = wr_en && (wr_addr % 4 == 0) && (wr_addr / 4 < 64);
      if (ferr)                          finst = 32'h0;
      else if (wok && wr_addr == req_addr) finst = wr_data;
      else                               finst = sh[req_addr / 4];
      if (flush) begin
        q.delete();
        for (int k = 0; k < 2; k++) begin
          m_valid[k] = 1'b0;
          m_inst[k]  = 32'h0;
          m_err[k]   = 1'b0;
        end
      end else if (!stall) begin
        if (acc) begin
          q.push_back('{0, 1, req_addr, finst, ferr});
          q.push_back('{1, 2, req_addr, finst, ferr});
        end
        for (int k = 0; k < 2; k++) m_valid[k] = 1'b0;
        nq.delete();
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          e.cnt = e.cnt - 1;
          if (e.cnt == 0) begin
            m_valid[e.k] = 1'b1;
            m_inst[e.k]  = e.inst;
            m_addr[e.k]  = e.addr;
            m_err[e.k]   = e.err;
          end else begin
            nq.push_back(e);
          end
        end
        q = nq;
      end
      if (wok) sh[wr_addr / 4] = wr_data;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("L%0d req_ready", k + 1), {63'h0, rr[k]}, {63'h0, (!stall && !flush && !rst)});
      check($sformatf("L%0d rsp_valid", k + 1), {63'h0, dv[k]}, {63'h0, m_valid[k]});
      check($sformatf("L%0d rsp_inst", k + 1), {32'h0, dinst[k]}, {32'h0, m_inst[k]});
      check($sformatf("L%0d rsp_addr", k + 1), {32'h0, daddr[k]}, {32'h0, m_addr[k]});
      if (m_valid[k]) check($sformatf("L%0d rsp_err", k + 1), {63'h0, derr[k]}, {63'h0, m_err[k]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; stall = 1'b0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(); step();
    check("reset rsp_valid", {63'h0, dv[0]}, 64'h0);
    check("reset rsp_inst", {32'h0, dinst[1]}, 64'h0);
    check("reset rsp_addr", {32'h0, daddr[1]}, 64'h0);
    check("reset req_ready", {63'h0, rr[0]}, 64'h0);
    rst = 1'b0;

    wr(32'h0,  32'h00221000);
    wr(32'h4,  32'h00432000);
    wr(32'h8,  32'h00008888);
    wr(32'hC,  32'h0000CCCC);
    wr(32'h10, 32'h10101010);
    wr(32'h14, 32'hAAAA0000);

    // Load and read back-to-back
    fetch(32'h0);
    check("t1 L1 inst0", {32'h0, dinst[0]}, 64'h00221000);
    check("t1 L1 valid0", {63'h0, dv[0]}, 64'h1);
    fetch(32'h4);
    check("t1 L1 inst1", {32'h0, dinst[0]}, 64'h00432000);
    check("t1 L1 addr1", {32'h0, daddr[0]}, 64'h4);
    check("t1 L2 inst0", {32'h0, dinst[1]}, 64'h00221000);
    req_valid = 1'b0;
    step();
    check("t1 L2 inst1", {32'h0, dinst[1]}, 64'h00432000);
    check("t1 L1 bubble", {63'h0, dv[0]}, 64'h0);
    check("t1 L1 hold", {32'h0, dinst[0]}, 64'h00432000);
    step();

    // Errors: misaligned, out of range, dropped write
    fetch(32'h2);
    check("t2 misalign err", {63'h0, derr[0]}, 64'h1);
    check("t2 misalign inst", {32'h0, dinst[0]}, 64'h0);
    fetch(32'h100);
    check("t2 range err", {63'h0, derr[0]}, 64'h1);
    check("t2 range addr", {32'h0, daddr[0]}, 64'h100);
    req_valid = 1'b0;
    wr(32'h100, 32'hDEADBEEF);
    fetch(32'h0);
    check("t2 mem0 kept", {32'h0, dinst[0]}, 64'h00221000);
    req_valid = 1'b0;
    step(); step();

    // Stall with two in flight
    fetch(32'h8);
    fetch(32'hC);
    check("t3 L2 first", {32'h0, dinst[1]}, 64'h00008888);
    stall = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3 stall inst", {32'h0, dinst[1]}, 64'h00008888);
      check("t3 stall ready", {63'h0, rr[1]}, 64'h0);
    end
    stall = 1'b0; req_valid = 1'b0;
    step();
    check("t3 L2 second", {32'h0, dinst[1]}, 64'h0000CCCC);
    step();
    check("t3 L2 drained", {63'h0, dv[1]}, 64'h0);

    // Flush one cycle after accepting 0x10
    fetch(32'h10);
    flush = 1'b1; req_addr = 32'h14;
    step();
    check("t3 flush valid", {63'h0, dv[1]}, 64'h0);
    check("t3 flush inst", {32'h0, dinst[1]}, 64'h0);
    flush = 1'b0; req_valid = 1'b0;
    step();
    check("t3 post flush", {63'h0, dv[1]}, 64'h0);
    step();

    // Read-during-write bypass
    wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h5555FFFF;
    fetch(32'h14);
    wr_en = 1'b0; req_valid = 1'b0;
    check("t4 L1 bypass", {32'h0, dinst[0]}, 64'h5555FFFF);
    step();
    check("t4 L2 bypass", {32'h0, dinst[1]}, 64'h5555FFFF);
    step();

    // Asynchronous reset mid-flight
    fetch(32'h0);
    req_valid = 1'b0;
    check("t5 L1 pre", {63'h0, dv[0]}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("t5 L1 async", {63'h0, dv[0]}, 64'h0);
    check("t5 L2 async", {63'h0, dv[1]}, 64'h0);
    #2 rst = 1'b0;
    step();
    check("t5 L2 lost", {63'h0, dv[1]}, 64'h0);
    step();
    fetch(32'h0);
    req_valid = 1'b0;
    step();
    check("t5 L2 refetch", {32'h0, dinst[1]}, 64'h00221000);
    check("t5 L2 valid", {63'h0, dv[1]}, 64'h1);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
